// File: rtl/uart_pkg.sv
// Shared UART parameters and helpers used by the rx, tx and tx-FIFO blocks.
// Latency: none (declarations only).
// Backpressure: not applicable.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_ADDR_BITS = 4;

    // Head-register load source in the transmit FIFO.
    typedef enum logic [1:0] {
        HEAD_HOLD,
        HEAD_RAM,
        HEAD_BYP,
        HEAD_DIN
    } head_sel_e;

    function automatic int fifo_depth(input int addr_bits);
        return 1 << addr_bits;
    endfunction

endpackage

// File: rtl/uart_bram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port.
// Latency: 1 cycle read; a same-address read and write returns the old word.
// Backpressure: none, both ports accept every cycle.
module uart_bram_sdp
    import uart_pkg::*;
#(
    parameter int dataBits = UART_DATA_BITS,
    parameter int addrBits = UART_ADDR_BITS
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [addrBits-1:0] waddr_i,
    input  logic [dataBits-1:0] wdata_i,
    input  logic [addrBits-1:0] raddr_i,
    output logic [dataBits-1:0] rdata_o
);

    logic [dataBits-1:0] mem_q [2**addrBits];
    logic [dataBits-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through transmit FIFO feeding the UART serialiser.
// Latency: a write into an empty FIFO is visible one cycle later; pops are zero-bubble.
// Backpressure: full rejects writes (sticky overflow); pops while empty are ignored (sticky underflow).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int dataBits = UART_DATA_BITS,
    parameter int addrBits = UART_ADDR_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wrEn,
    input  logic [dataBits-1:0] dataIn,
    output logic                full,
    input  logic                rdEn,
    output logic [dataBits-1:0] dataOut,
    output logic                notEmpty,
    output logic [addrBits:0]   count,
    output logic                overflow,
    output logic                underflow
);

    localparam int               DEPTH   = fifo_depth(addrBits);
    localparam logic [addrBits:0] DEPTH_C = (addrBits+1)'(DEPTH);
    localparam logic [addrBits:0] TWO_C   = (addrBits+1)'(2);

    logic [addrBits-1:0] wr_ptr_q, wr_ptr_d;
    logic [addrBits-1:0] rd_ptr_q, rd_ptr_d;
    logic [addrBits-1:0] ram_raddr;
    logic [addrBits:0]   count_q, count_d;
    logic                full_q, ne_q;
    logic                ovf_q, unf_q;
    logic [dataBits-1:0] dout_q, dout_d;
    logic                stale_q, stale_d;
    logic [dataBits-1:0] byp_q, byp_d;
    logic [dataBits-1:0] ram_rdata;
    logic                wr_acc, pop_acc;
    head_sel_e           head_sel;

    always_comb begin
        wr_acc    = wrEn && !full_q;
        pop_acc   = rdEn && ne_q;
        wr_ptr_d  = wr_acc  ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
        // The RAM always prefetches the word behind the (next) head.
        ram_raddr = rd_ptr_d + 1'b1;

        count_d = count_q;
        case ({wr_acc, pop_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        head_sel = HEAD_HOLD;
        if (pop_acc) begin
            if (count_q >= TWO_C) begin
                head_sel = stale_q ? HEAD_BYP : HEAD_RAM;
            end else if (wr_acc) begin
                head_sel = HEAD_DIN;
            end
        end else if (!ne_q && wr_acc) begin
            head_sel = HEAD_DIN;
        end

        dout_d = dout_q;
        case (head_sel)
            HEAD_RAM:  dout_d = ram_rdata;
            HEAD_BYP:  dout_d = byp_q;
            HEAD_DIN:  dout_d = dataIn;
            default:   dout_d = dout_q;
        endcase

        // Writing the very word being prefetched this edge leaves the RAM read stale.
        stale_d = wr_acc && (wr_ptr_q == ram_raddr);
        byp_d   = stale_d ? dataIn : byp_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            ne_q     <= 1'b0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            stale_q  <= 1'b0;
            byp_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == DEPTH_C);
            ne_q     <= (count_d != '0);
            dout_q   <= dout_d;
            ovf_q    <= ovf_q | (wrEn & full_q);
            unf_q    <= unf_q | (rdEn & ~ne_q);
            stale_q  <= stale_d;
            byp_q    <= byp_d;
        end
    end

    uart_bram_sdp #(
        .dataBits (dataBits),
        .addrBits (addrBits)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_acc && !reset),
        .waddr_i (wr_ptr_q),
        .wdata_i (dataIn),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    assign full      = full_q;
    assign notEmpty  = ne_q;
    assign dataOut   = dout_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboarded bench for uart_tx_fifo with directed vectors and a UART-tx style consumer.
module tb_uart_tx_fifo;

    localparam int DEPTH   = 16;
    localparam int TX_BUSY = 6;
    localparam int N_TX    = 40;

    logic       clk = 1'b0;
    logic       reset, wrEn, rdEn, rd_drv, tx_mode, tx_ready;
    logic [7:0] dataIn, dataOut;
    logic       full, notEmpty, overflow, underflow;
    logic [4:0] count;

    always #5 clk = ~clk;

    assign rdEn = tx_mode ? tx_ready : rd_drv;

    uart_tx_fifo #(.dataBits(8), .addrBits(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .wrEn      (wrEn),
        .dataIn    (dataIn),
        .full      (full),
        .rdEn      (rdEn),
        .dataOut   (dataOut),
        .notEmpty  (notEmpty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: expected contents, count and sticky flags.
    logic [7:0] sb[$];
    int         m_cnt = 0;
    bit         m_ovf = 1'b0;
    bit         m_unf = 1'b0;
    int         max_cnt = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                sb.delete();
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end else begin
                if (wrEn && m_cnt == DEPTH) m_ovf = 1'b1;
                if (rdEn && m_cnt == 0)     m_unf = 1'b1;
                if (rdEn && m_cnt > 0)      void'(sb.pop_front());
                if (wrEn && m_cnt < DEPTH)  sb.push_back(dataIn);
            end
            m_cnt = sb.size();
        end
    end

    // Monitor: compares the DUT against the model away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (int'(count) > max_cnt) max_cnt = int'(count);
            chk("count", count, m_cnt);
            chk("notEmpty", notEmpty, m_cnt > 0);
            chk("full", full, m_cnt == DEPTH);
            chk("overflow", overflow, m_ovf);
            chk("underflow", underflow, m_unf);
            if (rdEn && notEmpty) begin
                if (sb.size() == 0) chk("pop_unexpected", 1, 0);
                else                chk("pop_data", dataOut, sb[0]);
            end else if (m_cnt > 0) begin
                chk("head_data", dataOut, sb[0]);
            end
        end
    end

    // Serialiser stand-in: ready when idle, busy for TX_BUSY cycles per word.
    logic [7:0] tx_got[$];
    int         busy = 0;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (tx_mode) begin
                if (busy > 0) begin
                    busy--;
                    tx_ready = 1'b0;
                end else begin
                    tx_ready = 1'b1;
                    if (notEmpty) begin
                        tx_got.push_back(dataOut);
                        busy = TX_BUSY;
                    end
                end
            end else begin
                tx_ready = 1'b0;
                busy     = 0;
            end
        end
    end

    initial begin
        reset = 1'b1; wrEn = 1'b0; rd_drv = 1'b0; dataIn = 8'h00;
        tx_mode = 1'b0; tx_ready = 1'b0;
        repeat (2) tick();
        chk("rst_count", count, 0);
        chk("rst_dout", dataOut, 0);
        chk("rst_ne", notEmpty, 0);
        chk("rst_flags", {full, overflow, underflow}, 0);
        reset = 1'b0;

        // Single write, then pop to empty: head holds last word.
        wrEn = 1'b1; dataIn = 8'hA5; tick(); wrEn = 1'b0;
        chk("wr1_ne", notEmpty, 1);
        chk("wr1_dout", dataOut, 8'hA5);
        chk("wr1_count", count, 1);
        rd_drv = 1'b1; tick(); rd_drv = 1'b0;
        chk("pop1_ne", notEmpty, 0);
        chk("pop1_dout_hold", dataOut, 8'hA5);

        // Fill to full across pointer wrap, then reject writes.
        for (int i = 1; i <= 16; i++) begin
            wrEn = 1'b1; dataIn = 8'(i); tick();
        end
        wrEn = 1'b0;
        chk("fill_full", full, 1);
        chk("fill_count", count, 16);
        chk("fill_head", dataOut, 8'h01);
        wrEn = 1'b1; dataIn = 8'hFF; tick(); wrEn = 1'b0;
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, 16);
        // Full with simultaneous pop: the write is still rejected.
        wrEn = 1'b1; dataIn = 8'hEE; rd_drv = 1'b1; tick(); wrEn = 1'b0;
        chk("fullpop_count", count, 15);
        for (int i = 2; i <= 16; i++) begin
            chk("drain_order", dataOut, i);
            chk("drain_ne", notEmpty, 1);
            tick();
        end
        rd_drv = 1'b0;
        chk("drain_count", count, 0);
        chk("drain_dout_hold", dataOut, 8'h10);

        // Pop while empty.
        rd_drv = 1'b1; tick(); rd_drv = 1'b0;
        chk("unf_set", underflow, 1);
        chk("unf_count", count, 0);
        chk("unf_ne", notEmpty, 0);

        // count==1: pop and write on the same edge.
        wrEn = 1'b1; dataIn = 8'h11; tick();
        dataIn = 8'h22; rd_drv = 1'b1; tick(); wrEn = 1'b0; rd_drv = 1'b0;
        chk("popwr_dout", dataOut, 8'h22);
        chk("popwr_ne", notEmpty, 1);
        chk("popwr_count", count, 1);
        rd_drv = 1'b1; tick(); rd_drv = 1'b0;

        // Second word written right behind the head, popped immediately.
        wrEn = 1'b1; dataIn = 8'h31; tick();
        dataIn = 8'h32; tick(); wrEn = 1'b0;
        rd_drv = 1'b1; tick();
        chk("byp_dout", dataOut, 8'h32);
        wrEn = 1'b1; dataIn = 8'h33; tick(); wrEn = 1'b0;
        chk("byp_popwr", dataOut, 8'h33);
        chk("byp_count", count, 1);
        tick(); rd_drv = 1'b0;

        // Three words, back-to-back pops served from RAM.
        for (int i = 0; i < 3; i++) begin
            wrEn = 1'b1; dataIn = 8'h41 + 8'(i); tick();
        end
        wrEn = 1'b0; rd_drv = 1'b1;
        tick(); chk("ram_pop1", dataOut, 8'h42);
        tick(); chk("ram_pop2", dataOut, 8'h43);
        tick(); rd_drv = 1'b0;
        chk("ram_empty", notEmpty, 0);

        // Reset mid-operation overrides simultaneous requests.
        for (int i = 0; i < 7; i++) begin
            wrEn = 1'b1; dataIn = 8'h61 + 8'(i); tick();
        end
        wrEn = 1'b0;
        chk("pre_rst_count", count, 7);
        reset = 1'b1; wrEn = 1'b1; rd_drv = 1'b1; dataIn = 8'h77; tick();
        reset = 1'b0; wrEn = 1'b0; rd_drv = 1'b0;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_ne", notEmpty, 0);
        chk("mid_rst_flags", {full, overflow, underflow}, 0);
        chk("mid_rst_dout", dataOut, 0);
        wrEn = 1'b1; dataIn = 8'h5A; tick(); wrEn = 1'b0;
        chk("post_rst_dout", dataOut, 8'h5A);
        chk("post_rst_ne", notEmpty, 1);
        rd_drv = 1'b1; tick(); rd_drv = 1'b0;

        // Stream through the serialiser stand-in.
        reset = 1'b1; tick(); reset = 1'b0;
        tx_mode = 1'b1;
        for (int i = 0; i < N_TX; i++) begin
            int guard = 0;
            while (m_cnt >= DEPTH && guard < 2000) begin
                wrEn = 1'b0; tick(); guard++;
            end
            wrEn = 1'b1; dataIn = 8'h80 + 8'(i); tick();
        end
        wrEn = 1'b0;
        begin
            int guard = 0;
            while ((tx_got.size() < N_TX || m_cnt != 0) && guard < 3000) begin
                tick(); guard++;
            end
            chk("tx_drain_done", guard < 3000, 1);
        end
        tx_mode = 1'b0;
        chk("tx_words", tx_got.size(), N_TX);
        for (int i = 0; i < N_TX && i < tx_got.size(); i++) begin
            chk("tx_order", tx_got[i], 8'h80 + 8'(i));
        end
        chk("tx_max_count", max_cnt <= DEPTH, 1);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter dataBits, default 8, width of one UART data word.
REQ-002 SHALL have parameter addrBits, default 4; depth DEPTH = 2**addrBits words, output register included.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wrEn  input  1  write request from the host side.
REQ-006 SHALL have port dataIn  input  dataBits  word to write.
REQ-007 SHALL have port full  output  1  high when count == DEPTH.
REQ-008 SHALL have port rdEn  input  1  pop request; driven by uartTx txReady.
REQ-009 SHALL have port dataOut  output  dataBits  head word (first-word-fall-through); feeds uartTx dataIn.
REQ-010 SHALL have port notEmpty  output  1  head valid; feeds uartTx fifoNE.
REQ-011 SHALL have port count  output  addrBits+1  stored words, 0..DEPTH.
REQ-012 SHALL have port overflow  output  1  sticky: write rejected because full.
REQ-013 SHALL have port underflow  output  1  sticky: pop requested while empty.

Function
REQ-014 SHALL accept a write when wrEn=1 and registered full=0; the word is stored at the tail.
REQ-015 SHALL reject a write when full=1, even if a pop is accepted in the same cycle; contents unchanged; overflow set next edge.
REQ-016 SHALL accept a pop when rdEn=1 and notEmpty=1; the head is discarded.
REQ-017 SHALL ignore a pop when notEmpty=0; underflow set next edge.
REQ-018 SHALL present dataOut and notEmpty from registers; no combinational path from any input to any output.
REQ-019 SHALL hold dataOut stable while notEmpty=1 and no pop is accepted.
REQ-020 Write into an empty FIFO at edge N SHALL give notEmpty=1 and dataOut=that word after edge N (one-cycle latency).
REQ-021 Pop at edge N with count>=2 SHALL give the next word on dataOut after edge N, with notEmpty staying 1 (zero-bubble).
REQ-022 Pop at edge N with count==1 and no accepted write SHALL give notEmpty=0 after edge N; dataOut holds its last value.
REQ-023 Simultaneous accepted pop and write with count==1 SHALL give the written word on dataOut after edge N, with notEmpty=1.
REQ-024 Simultaneous accepted write and ignored pop with count==0 SHALL behave as REQ-020, with underflow set.
REQ-025 count SHALL update every edge: +1 on write only, -1 on pop only, unchanged on both or neither; it never wraps.
REQ-026 Storage beyond the head SHALL be a synchronous-read RAM (1-cycle read), with read address pre-advanced on pop (speculative prefetch).
REQ-027 A write-to-head bypass SHALL cover words not yet readable from RAM, so REQ-020/021/023 hold.
REQ-028 Read and write pointers SHALL be addrBits wide and wrap modulo DEPTH.
REQ-029 Words SHALL emerge in write order with no loss, duplication or reordering across pointer wrap.

Reset
REQ-030 While reset=1 at an edge, the FIFO SHALL: set count=0, notEmpty=0, full=0, dataOut=0, overflow=0, underflow=0, and both pointers to 0.
REQ-031 Reset SHALL override simultaneous wrEn/rdEn; a reset mid-operation SHALL discard all stored words.
REQ-032 RAM contents need not be cleared; stale data SHALL never be visible after reset.
REQ-033 overflow and underflow SHALL clear only on reset.

Structure
REQ-034 DEPTH derivation and default dataBits/addrBits SHALL live in the shared UART package, used by uartRx/uartTx/uart_tx_fifo.
REQ-035 The RAM SHALL be a sub-module uart_bram_sdp: simple dual-port, one write port and one registered read port, parameterised by dataBits and addrBits.

Verification
REQ-036 Reset, then write 0xA5 at a single edge -> next cycle notEmpty=1, dataOut=0xA5, count=1.
REQ-037 Write 0x01..0x10 back-to-back (DEPTH=16) -> full=1 and count=16; extra write 0xFF -> rejected, overflow=1; pops return 0x01..0x10 in order with no bubble.
REQ-038 count==1 (0x11), same edge pop plus write 0x22 -> dataOut=0x22, notEmpty=1, count=1.
REQ-039 Empty FIFO, rdEn=1 for one cycle -> underflow=1, count=0, notEmpty=0.
REQ-040 Drive 40 words through with uartTx attached (rdEn=txReady) -> tx line serialises all 40 in order; count never exceeds 16.
REQ-041 Assert reset with count=7 mid-transfer -> next cycle count=0, notEmpty=0, flags 0; the next write appears in one cycle.
